// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus bundle: instruction ROM port, redirect from execute,
// and the valid/ready hand-off to decode.
// Optional: PC_ALIGN_CHECK_EN adds misalign_out / misalign_pc_out.
interface fetch_queue_unit_if #(
    parameter int PC_W  = 32,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // instruction ROM
    logic             imem_req_out;
    logic [PC_W-1:0]  imem_addr_out;
    logic [INS_W-1:0] imem_data_in;

    // redirect from execute
    logic             redirect_in;
    logic [PC_W-1:0]  redirect_pc_in;

    // decode hand-off
    logic             dec_ready_in;
    logic             dec_valid_out;
    logic [INS_W-1:0] dec_ins_out;
    logic [PC_W-1:0]  dec_pc_out;
    logic [PC_W-1:0]  dec_pcn_out;
    logic [CNT_W-1:0] count_out;

`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_out;
    logic [PC_W-1:0]  misalign_pc_out;
`endif

    // fetch unit side
    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_data_in,
        input  redirect_in, redirect_pc_in,
        input  dec_ready_in,
        output dec_valid_out, dec_ins_out, dec_pc_out, dec_pcn_out,
        output count_out
`ifdef PC_ALIGN_CHECK_EN
        , output misalign_out, misalign_pc_out
`endif
    );

    // ROM / execute / decode side
    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_data_in,
        output redirect_in, redirect_pc_in,
        output dec_ready_in,
        input  dec_valid_out, dec_ins_out, dec_pc_out, dec_pcn_out,
        input  count_out
`ifdef PC_ALIGN_CHECK_EN
        , input misalign_out, misalign_pc_out
`endif
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to a 1-cycle
// synchronous instruction ROM, and buffers returned words with PC and PC+4
// in a DEPTH-entry queue drained by decode over valid/ready. A redirect
// flushes the queue and squashes the read in flight.
// Optional: define PC_ALIGN_CHECK_EN to word-align redirect targets and
// report the first misaligned target on misalign_out / misalign_pc_out.
module fetch_queue_unit #(
    parameter int              PC_W     = 32,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 'h0040_0000
) (
    input logic               clock,
    input logic               reset,
    fetch_queue_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // architectural state
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // queue storage (no reset needed: empty queue masks the outputs)
    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PC_W-1:0]  pcn_mem [DEPTH];

    // next-state values
    logic [PC_W-1:0]  fetch_pc_nxt;
    logic [PC_W-1:0]  inflight_pc_nxt;
    logic             inflight_nxt;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic [CNT_W-1:0] count_nxt;

    // per-cycle controls
    logic             redirect;
    logic [PC_W-1:0]  target;
    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [CNT_W-1:0] occupancy;

    assign redirect = bus.redirect_in;

`ifdef PC_ALIGN_CHECK_EN
    assign target = {bus.redirect_pc_in[PC_W-1:2], 2'b00};
`else
    assign target = bus.redirect_pc_in;
`endif

    // Issue/push/pop decisions and next-state computation; redirect wins
    // over everything else.
    always_comb begin
        head_valid      = (count != '0);
        occupancy       = count + CNT_W'(inflight);
        // issue is held off while reset is asserted so the ROM sees no
        // request during reset even though the state reads as empty
        issue           = !reset && !redirect && (occupancy < CNT_W'(DEPTH));
        push            = inflight && !redirect;
        pop             = head_valid && bus.dec_ready_in && !redirect;

        fetch_pc_nxt    = fetch_pc;
        inflight_pc_nxt = inflight_pc;
        inflight_nxt    = issue;
        head_nxt        = head;
        tail_nxt        = tail;
        count_nxt       = count;

        if (redirect) begin
            fetch_pc_nxt = target;
            head_nxt     = '0;
            tail_nxt     = '0;
            count_nxt    = '0;
        end else begin
            if (issue) begin
                fetch_pc_nxt    = fetch_pc + PC_W'(4);
                inflight_pc_nxt = fetch_pc;
            end
            if (push) begin
                tail_nxt = tail + PTR_W'(1);
            end
            if (pop) begin
                head_nxt = head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            inflight_pc <= inflight_pc_nxt;
            inflight    <= inflight_nxt;
            head        <= head_nxt;
            tail        <= tail_nxt;
            count       <= count_nxt;
        end
    end

    // Write the returning ROM word into the tail slot.
    always_ff @(posedge clock) begin
        if (push) begin
            ins_mem[tail] <= bus.imem_data_in;
            pc_mem[tail]  <= inflight_pc;
            pcn_mem[tail] <= inflight_pc + PC_W'(4);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic            misalign;
    logic [PC_W-1:0] misalign_pc;

    // Sticky flag; only the first offending target is recorded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalign    <= 1'b0;
            misalign_pc <= '0;
        end else if (redirect && (bus.redirect_pc_in[1:0] != 2'b00) && !misalign) begin
            misalign    <= 1'b1;
            misalign_pc <= bus.redirect_pc_in;
        end
    end

    assign bus.misalign_out    = misalign;
    assign bus.misalign_pc_out = misalign_pc;
`endif

    // Output drive; head fields read as zero when the queue is empty.
    always_comb begin
        bus.imem_req_out  = issue;
        bus.imem_addr_out = fetch_pc;
        bus.dec_valid_out = head_valid;
        bus.dec_ins_out   = head_valid ? ins_mem[head] : '0;
        bus.dec_pc_out    = head_valid ? pc_mem[head]  : '0;
        bus.dec_pcn_out   = head_valid ? pcn_mem[head] : '0;
        bus.count_out     = count;
    end

    // The issue credit must always leave room for a return.
    assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (DEPTH=4). Inputs are driven 1ns after
// the rising edge and outputs sampled on the falling edge. The ROM model
// returns addr ^ 32'hA5A5_0000 one cycle after a request.
module tb_fetch_queue_unit;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] rom_q;

    fetch_queue_unit_if #(.PC_W(32), .INS_W(32), .DEPTH(4)) bus ();

    fetch_queue_unit #(
        .PC_W    (32),
        .INS_W   (32),
        .DEPTH   (4),
        .RESET_PC(RST_PC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // synchronous ROM, one-cycle read latency
    always_ff @(posedge clock) begin
        if (bus.imem_req_out) rom_q <= rom_word(bus.imem_addr_out);
    end
    assign bus.imem_data_in = rom_q;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // leaves the bench at the drive point of cycle 0 after release
    task automatic do_reset(input logic rdy);
        reset              = 1'b1;
        bus.redirect_in    = 1'b0;
        bus.redirect_pc_in = '0;
        bus.dec_ready_in   = rdy;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset              = 1'b0;
        bus.redirect_in    = 1'b0;
        bus.redirect_pc_in = '0;
        bus.dec_ready_in   = 1'b1;
        #2 reset = 1'b1;
        smp();
        total++;
        if (bus.imem_req_out !== 1'b0) begin
            bad++; $display("FAIL reset_req got %b want 0", bus.imem_req_out);
        end
        total++;
        if (bus.imem_addr_out !== RST_PC) begin
            bad++; $display("FAIL reset_addr got %h want %h", bus.imem_addr_out, RST_PC);
        end
        total++;
        if ({bus.dec_valid_out, bus.dec_ins_out, bus.dec_pc_out, bus.dec_pcn_out} !== 97'd0) begin
            bad++; $display("FAIL reset_dec got v=%b ins=%h pc=%h pcn=%h want all 0",
                bus.dec_valid_out, bus.dec_ins_out, bus.dec_pc_out, bus.dec_pcn_out);
        end
        total++;
        if (bus.count_out !== 3'd0) begin
            bad++; $display("FAIL reset_count got %0d want 0", bus.count_out);
        end
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if ({bus.misalign_out, bus.misalign_pc_out} !== 33'd0) begin
            bad++; $display("FAIL reset_misalign got %b %h want 0 0", bus.misalign_out, bus.misalign_pc_out);
        end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1'b1);
        smp();
        total++;
        if ({bus.dec_valid_out, bus.imem_req_out, bus.imem_addr_out} !== {1'b0, 1'b1, RST_PC}) begin
            bad++; $display("FAIL stream_c0 got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                bus.dec_valid_out, bus.imem_req_out, bus.imem_addr_out, RST_PC);
        end
        cyc(); smp();
        total++;
        if ({bus.dec_valid_out, bus.imem_addr_out} !== {1'b0, 32'h0040_0004}) begin
            bad++; $display("FAIL stream_c1 got v=%b addr=%h want v=0 addr=00400004",
                bus.dec_valid_out, bus.imem_addr_out);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(); smp();
            e = RST_PC + 32'(4 * i);
            total++;
            if ({bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out, bus.dec_ins_out, bus.count_out}
                !== {1'b1, e, e + 32'd4, rom_word(e), 3'd1}) begin
                bad++; $display("FAIL stream_head[%0d] got v=%b pc=%h pcn=%h ins=%h cnt=%0d want pc=%h",
                    i, bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out, bus.dec_ins_out, bus.count_out, e);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic        f_req [9]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        logic [2:0]  f_cnt [9]  = '{0, 0, 1, 2, 3, 4, 4, 4, 4};
        logic        d_req [5]  = '{0, 1, 1, 1, 1};
        logic [2:0]  d_cnt [5]  = '{4, 3, 2, 2, 2};
        logic [31:0] d_addr[5]  = '{32'h0040_0010, 32'h0040_0010, 32'h0040_0014,
                                    32'h0040_0018, 32'h0040_001C};
        logic [31:0] d_pc  [5]  = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008,
                                    32'h0040_000C, 32'h0040_0010};
        do_reset(1'b0);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) cyc();
            smp();
            total++;
            if ({bus.imem_req_out, bus.count_out} !== {f_req[c], f_cnt[c]}) begin
                bad++; $display("FAIL fill[c%0d] got req=%b cnt=%0d want req=%b cnt=%0d",
                    c, bus.imem_req_out, bus.count_out, f_req[c], f_cnt[c]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            cyc();
            bus.dec_ready_in = 1'b1;
            smp();
            total++;
            if ({bus.imem_req_out, bus.count_out, bus.imem_addr_out, bus.dec_valid_out,
                 bus.dec_pc_out, bus.dec_ins_out}
                !== {d_req[c], d_cnt[c], d_addr[c], 1'b1, d_pc[c], rom_word(d_pc[c])}) begin
                bad++; $display("FAIL drain[c%0d] got req=%b cnt=%0d addr=%h v=%b pc=%h ins=%h want req=%b cnt=%0d addr=%h pc=%h",
                    c + 9, bus.imem_req_out, bus.count_out, bus.imem_addr_out, bus.dec_valid_out,
                    bus.dec_pc_out, bus.dec_ins_out, d_req[c], d_cnt[c], d_addr[c], d_pc[c]);
            end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset(1'b0);
        cyc(); cyc(); cyc(); cyc();
        // cycle 4: three queued, 0x0040000C in flight
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h0040_0100;
        smp();
        total++;
        if ({bus.count_out, bus.imem_req_out} !== {3'd3, 1'b0}) begin
            bad++; $display("FAIL flush_pre got cnt=%0d req=%b want cnt=3 req=0", bus.count_out, bus.imem_req_out);
        end
        cyc();
        bus.redirect_in = 1'b0;
        smp();
        total++;
        if ({bus.dec_valid_out, bus.count_out, bus.imem_req_out, bus.imem_addr_out}
            !== {1'b0, 3'd0, 1'b1, 32'h0040_0100}) begin
            bad++; $display("FAIL flush_t1 got v=%b cnt=%0d req=%b addr=%h want 0 0 1 00400100",
                bus.dec_valid_out, bus.count_out, bus.imem_req_out, bus.imem_addr_out);
        end
        cyc(); smp();
        total++;
        if ({bus.dec_valid_out, bus.count_out} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL flush_t2 got v=%b cnt=%0d want v=0 cnt=0", bus.dec_valid_out, bus.count_out);
        end
        cyc(); smp();
        total++;
        if ({bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out, bus.dec_ins_out, bus.count_out}
            !== {1'b1, 32'h0040_0100, 32'h0040_0104, rom_word(32'h0040_0100), 3'd1}) begin
            bad++; $display("FAIL flush_t3 got v=%b pc=%h pcn=%h ins=%h cnt=%0d want pc=00400100 cnt=1",
                bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out, bus.dec_ins_out, bus.count_out);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b1);
        cyc(); cyc(); cyc(); cyc();
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h0000_0200;
        smp();
        total++;
        if ({bus.dec_valid_out, bus.dec_pc_out, bus.count_out} !== {1'b1, 32'h0040_0008, 3'd1}) begin
            bad++; $display("FAIL rpop_pre got v=%b pc=%h cnt=%0d want 1 00400008 1",
                bus.dec_valid_out, bus.dec_pc_out, bus.count_out);
        end
        cyc();
        bus.redirect_pc_in = 32'h0000_0300;
        smp();
        total++;
        if ({bus.dec_valid_out, bus.count_out, bus.imem_req_out} !== {1'b0, 3'd0, 1'b0}) begin
            bad++; $display("FAIL rpop_flush got v=%b cnt=%0d req=%b want 0 0 0",
                bus.dec_valid_out, bus.count_out, bus.imem_req_out);
        end
        cyc();
        bus.redirect_in = 1'b0;
        smp();
        total++;
        if ({bus.imem_req_out, bus.imem_addr_out} !== {1'b1, 32'h0000_0300}) begin
            bad++; $display("FAIL rpop_req got req=%b addr=%h want 1 00000300", bus.imem_req_out, bus.imem_addr_out);
        end
        cyc(); smp();
        total++;
        if (bus.dec_valid_out !== 1'b0) begin
            bad++; $display("FAIL rpop_gap got v=%b want 0", bus.dec_valid_out);
        end
        cyc(); smp();
        total++;
        if ({bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out} !== {1'b1, 32'h0000_0300, 32'h0000_0304}) begin
            bad++; $display("FAIL rpop_first got v=%b pc=%h pcn=%h want 1 00000300 00000304",
                bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out);
        end
        cyc(); smp();
        total++;
        if (bus.dec_pc_out !== 32'h0000_0304) begin
            bad++; $display("FAIL rpop_second got pc=%h want 00000304", bus.dec_pc_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        cyc(); cyc(); cyc(); cyc();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.dec_valid_out, bus.count_out, bus.imem_req_out, bus.imem_addr_out}
            !== {1'b0, 3'd0, 1'b0, RST_PC}) begin
            bad++; $display("FAIL async_rst got v=%b cnt=%0d req=%b addr=%h want 0 0 0 %h",
                bus.dec_valid_out, bus.count_out, bus.imem_req_out, bus.imem_addr_out, RST_PC);
        end
        cyc();
        reset = 1'b0;
        smp();
        total++;
        if ({bus.imem_req_out, bus.imem_addr_out} !== {1'b1, RST_PC}) begin
            bad++; $display("FAIL async_restart got req=%b addr=%h want 1 %h", bus.imem_req_out, bus.imem_addr_out, RST_PC);
        end
        cyc(); cyc(); smp();
        total++;
        if ({bus.dec_valid_out, bus.dec_pc_out} !== {1'b1, RST_PC}) begin
            bad++; $display("FAIL async_first got v=%b pc=%h want 1 %h", bus.dec_valid_out, bus.dec_pc_out, RST_PC);
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] w_addr[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        logic [31:0] w_pc  [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        logic [31:0] w_pcn [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset(1'b1);
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'hFFFF_FFF8;
        cyc();
        bus.redirect_in = 1'b0;
        smp();
        total++;
        if ({bus.imem_req_out, bus.imem_addr_out} !== {1'b1, 32'hFFFF_FFF8}) begin
            bad++; $display("FAIL wrap_req got req=%b addr=%h want 1 fffffff8", bus.imem_req_out, bus.imem_addr_out);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            // first iteration is T+2: nothing delivered yet, only the address advances
            total++;
            if (i == 0) begin
                if ({bus.dec_valid_out, bus.imem_addr_out} !== {1'b0, w_addr[0]}) begin
                    bad++; $display("FAIL wrap_t2 got v=%b addr=%h want 0 %h", bus.dec_valid_out, bus.imem_addr_out, w_addr[0]);
                end
            end else begin
                if ({bus.dec_valid_out, bus.imem_addr_out, bus.dec_pc_out, bus.dec_pcn_out}
                    !== {1'b1, w_addr[i], w_pc[i-1], w_pcn[i-1]}) begin
                    bad++; $display("FAIL wrap_head[%0d] got v=%b addr=%h pc=%h pcn=%h want addr=%h pc=%h pcn=%h",
                        i, bus.dec_valid_out, bus.imem_addr_out, bus.dec_pc_out, bus.dec_pcn_out,
                        w_addr[i], w_pc[i-1], w_pcn[i-1]);
                end
            end
        end
        cyc(); smp();
        total++;
        if ({bus.dec_pc_out, bus.dec_pcn_out} !== {w_pc[2], w_pcn[2]}) begin
            bad++; $display("FAIL wrap_zero got pc=%h pcn=%h want 00000000 00000004", bus.dec_pc_out, bus.dec_pcn_out);
        end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h0040_0100;
`else
        exp_pc = 32'h0040_0102;
`endif
        do_reset(1'b1);
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h0040_0102;
        cyc();
        bus.redirect_in = 1'b0;
        smp();
        total++;
        if (bus.imem_addr_out !== exp_pc) begin
            bad++; $display("FAIL align_addr got %h want %h", bus.imem_addr_out, exp_pc);
        end
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if ({bus.misalign_out, bus.misalign_pc_out} !== {1'b1, 32'h0040_0102}) begin
            bad++; $display("FAIL align_flag got %b %h want 1 00400102", bus.misalign_out, bus.misalign_pc_out);
        end
`endif
        cyc(); cyc();
        // second misaligned redirect must not overwrite the captured target
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h0040_0206;
        smp();
        total++;
        if ({bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out} !== {1'b1, exp_pc, exp_pc + 32'd4}) begin
            bad++; $display("FAIL align_head got v=%b pc=%h pcn=%h want pc=%h",
                bus.dec_valid_out, bus.dec_pc_out, bus.dec_pcn_out, exp_pc);
        end
        cyc();
        bus.redirect_in = 1'b0;
        smp();
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if ({bus.misalign_out, bus.misalign_pc_out} !== {1'b1, 32'h0040_0102}) begin
            bad++; $display("FAIL align_sticky got %b %h want 1 00400102", bus.misalign_out, bus.misalign_pc_out);
        end
`endif
        total++;
        if (bus.imem_addr_out !== (exp_pc + 32'h0000_0104)) begin
            bad++; $display("FAIL align_second got %h want %h", bus.imem_addr_out, exp_pc + 32'h0000_0104);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect_flush();
        test_redirect_pop();
        test_async_reset();
        test_pc_wrap();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch stage for the pipelined MIPS datapath.
- Replaces the single-cycle PC register/adder logic.
- Owns the fetch PC and issues addresses to the synchronous instruction ROM (1-cycle read latency).
- Buffers returned instructions with their PC and PC+4 in a DEPTH-entry queue and hands them to decode over a valid/ready handshake; a jump/branch/jr redirect flushes the queue and squashes in-flight reads.

Parameters:
RESET_PC, 32'h0040_0000, fetch PC after reset
DEPTH, 4, queue entries; power of two, >= 2
INS_W, 32, instruction width
PC_W, 32, PC width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req_out  out  1  read request to instruction ROM this cycle
imem_addr_out  out  PC_W  ROM read address (= fetch PC)
imem_data_in  in  INS_W  ROM data, valid the cycle after imem_req_out
redirect_in  in  1  taken branch/jump/jr from execute
redirect_pc_in  in  PC_W  redirect target
dec_ready_in  in  1  decode accepts head entry
dec_valid_out  out  1  queue head valid
dec_ins_out  out  INS_W  head instruction
dec_pc_out  out  PC_W  head instruction PC
dec_pcn_out  out  PC_W  head PC+4 (for jal/jalr link, branch base)
count_out  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-high.
- State on reset: fetch_pc=RESET_PC, queue empty, head/tail pointers 0, inflight=0, inflight_pc=0.
- Outputs during reset: imem_req_out=0, imem_addr_out=RESET_PC, dec_valid_out=0, dec_ins/pc/pcn_out=0, count_out=0.
- Reset mid-operation discards all entries and in-flight reads immediately.
- Issue rule, per cycle: imem_req_out=1 iff !redirect_in && (count + inflight) < DEPTH.
- Issue pop credit is not counted, so issue is conservative.
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- PC arithmetic is modulo 2^PC_W; 0xFFFF_FFFC+4 = 0.
- Return: when inflight=1, imem_data_in is written at tail with pc=inflight_pc and pcn=inflight_pc+4; inflight clears unless a new issue occurs that cycle.
- Full/credit: the credit rule guarantees a return always has a free slot; no overflow path exists.
- Pop: dec_valid_out && dec_ready_in advances head. Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- Empty: dec_valid_out=0; dec_ins/pc/pcn_out forced to 0.
- Redirect (redirect_in=1), taking priority over pop, push and issue:
  - queue flushed to empty;
  - inflight cleared, so the old-stream return arriving next cycle is dropped;
  - fetch_pc<=redirect_pc_in;
  - no request that cycle.
- Redirect timing: redirect in cycle T -> request at target in T+1 -> entry written at end of T+2 -> dec_valid_out=1 in T+3.
- Back-to-back redirects: the last one wins. Each redirect restarts the T+3 timing.
- Steady state with dec_ready_in=1 and no redirects: one instruction per cycle after a 2-cycle startup; first dec_valid_out is in cycle 2 after reset release.
- dec_ready_in=0 sustained: the queue fills to DEPTH, then imem_req_out stays 0 until a pop.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - redirect_pc_in[1:0]!=0 sets a sticky output misalign_out (1 bit, reset 0, cleared only by reset);
  - fetch_pc loads {redirect_pc_in[PC_W-1:2],2'b00};
  - misalign_pc_out (PC_W) captures the first offending target.
- When undefined: neither port exists; the target loads unmodified and the low bits pass to imem_addr_out.

Test Plan:
- Reset release, dec_ready_in=1, ROM returns word=addr -> entries PC 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; dec_pcn_out=PC+4; first valid cycle 2.
- dec_ready_in=0, DEPTH=4 -> count_out reaches 4 and imem_req_out=0 with no overflow. Then ready=1 -> one pop per cycle, request resumes the cycle after the first pop.
- redirect_in=1 with pc=0x00400100 while 3 entries queued and one in flight -> queue empty next cycle, stale return dropped, next delivered PC=0x00400100 in T+3.
- redirect_in and pop in the same cycle -> pop ignored, count_out=0; redirects in consecutive cycles to 0x200 then 0x300 -> first delivered PC=0x300.
- reset asserted asynchronously mid-stream -> dec_valid_out=0 and count_out=0 without a clock edge; after release, fetch restarts at 0x00400000.
- With PC_ALIGN_CHECK_EN, redirect to 0x00400102 -> misalign_out=1, misalign_pc_out=0x00400102, next fetch at 0x00400100; without the macro, imem_addr_out=0x00400102.
